// File: rtl/csr_mem_pkg.sv
// Shared constants for the CLINT-style CSR block: register selects, half selects
// and the mtimecmp reset value.
package csr_mem_pkg;

  localparam logic [1:0] CSR_MSIP     = 2'b00;
  localparam logic [1:0] CSR_MTIME    = 2'b01;
  localparam logic [1:0] CSR_MTIMECMP = 2'b10;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [31:0] selectHalf(input logic [63:0] value, input logic half);
    return (half == HALF_HI) ? value[63:32] : value[31:0];
  endfunction

endpackage

// File: rtl/csr_mem_if.sv
// Wishbone-style peripheral bus between the memory controller (master) and csr_mem (slave).
interface csr_mem_if;

  logic [2:0]  ADR_I;
  logic [31:0] DAT_I;
  logic        CYC_I;
  logic        STB_I;
  logic        WE_I;
  logic [31:0] DAT_O;
  logic        ACK_O;

  modport master (
    output ADR_I, DAT_I, CYC_I, STB_I, WE_I,
    input  DAT_O, ACK_O
  );

  modport slave (
    input  ADR_I, DAT_I, CYC_I, STB_I, WE_I,
    output DAT_O, ACK_O
  );

endinterface

// File: rtl/csr_mem_tick.sv
// mtime prescaler: counts 0..CLOCK_CYCLES-1 and flags the wrap cycle as a one-cycle tick.
module csr_mem_tick #(
  parameter int CLOCK_CYCLES = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  // A single-cycle period still needs a one-bit counter that simply stays at zero.
  localparam int CntW = (CLOCK_CYCLES > 1) ? $clog2(CLOCK_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLOCK_CYCLES - 1);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  always_comb begin
    tick_o = (cnt_q == CntLast);
    cnt_d  = tick_o ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/csr_mem.sv
// CLINT-like CSR block holding msip, the free-running mtime and mtimecmp,
// accessed over a single-cycle-latency Wishbone-style slave port.
module csr_mem
  import csr_mem_pkg::*;
#(
  parameter int CLOCK_CYCLES = 10
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  csr_mem_if.slave    bus,
  output logic        msip,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp
);

  logic        tick;
  logic        busReq;
  logic        busWr;
  logic        busRd;
  logic [1:0]  regSel;
  logic        halfSel;
  logic [31:0] rdData;

  logic        ack_q,      ack_d;
  logic [31:0] dat_q,      dat_d;
  logic [31:0] msipReg_q,  msipReg_d;
  logic [63:0] mtime_q,    mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;

  csr_mem_tick #(
    .CLOCK_CYCLES(CLOCK_CYCLES)
  ) u_tick (
    .clk_i (CLK_I),
    .rst_i (RST_I),
    .tick_o(tick)
  );

  always_comb begin
    busReq  = bus.CYC_I & bus.STB_I & ~ack_q;
    busWr   = busReq & bus.WE_I;
    busRd   = busReq & ~bus.WE_I;
    regSel  = bus.ADR_I[2:1];
    halfSel = bus.ADR_I[0];

    ack_d      = busReq;
    dat_d      = dat_q;
    msipReg_d  = msipReg_q;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    rdData     = '0;

    case (regSel)
      CSR_MSIP:     rdData = msipReg_q;
      CSR_MTIME:    rdData = selectHalf(mtime_q, halfSel);
      CSR_MTIMECMP: rdData = selectHalf(mtimecmp_q, halfSel);
      default:      rdData = '0;
    endcase

    if (busRd) begin
      dat_d = rdData;
    end

    // A write to one mtime half overrides the tick; the other half keeps its old value, no carry.
    if (busWr) begin
      case (regSel)
        CSR_MSIP: msipReg_d = bus.DAT_I;
        CSR_MTIME: begin
          if (halfSel == HALF_HI) mtime_d = {bus.DAT_I, mtime_q[31:0]};
          else                    mtime_d = {mtime_q[63:32], bus.DAT_I};
        end
        CSR_MTIMECMP: begin
          if (halfSel == HALF_HI) mtimecmp_d = {bus.DAT_I, mtimecmp_q[31:0]};
          else                    mtimecmp_d = {mtimecmp_q[63:32], bus.DAT_I};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      msipReg_q  <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= MTIMECMP_RST;
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      msipReg_q  <= msipReg_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
    end
  end

  assign bus.ACK_O = ack_q;
  assign bus.DAT_O = dat_q;
  assign msip      = msipReg_q[0];
  assign mtime     = mtime_q;
  assign mtimecmp  = mtimecmp_q;

endmodule

// File: tb/tb_csr_mem.sv
// Directed self-checking bench for csr_mem with CLOCK_CYCLES=10.
module tb_csr_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        msip;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;

  int errors = 0;
  int checks = 0;

  csr_mem_if busIf();

  csr_mem #(
    .CLOCK_CYCLES(10)
  ) dut (
    .CLK_I   (clk),
    .RST_I   (rst),
    .bus     (busIf),
    .msip    (msip),
    .mtime   (mtime),
    .mtimecmp(mtimecmp)
  );

  always #5 clk = ~clk;

  // One isolated access: request edge, sample, then an idle edge so ACK_O is low again.
  task automatic busAccess(input logic [2:0] adr, input logic we, input logic [31:0] data,
                           output logic ackSeen, output logic [31:0] datSeen,
                           output logic [63:0] mtimeSeen);
    busIf.ADR_I = adr;
    busIf.DAT_I = data;
    busIf.WE_I  = we;
    busIf.CYC_I = 1'b1;
    busIf.STB_I = 1'b1;
    @(posedge clk);
    #1;
    ackSeen   = busIf.ACK_O;
    datSeen   = busIf.DAT_O;
    mtimeSeen = mtime;
    busIf.CYC_I = 1'b0;
    busIf.STB_I = 1'b0;
    busIf.WE_I  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic        ack;
    logic [31:0] dat;
    logic [63:0] mt;
    int          ackHigh;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busIf.ACK_O !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack got=%0b exp=0", busIf.ACK_O); end
    checks++;
    if (busIf.DAT_O !== 32'h0) begin errors++; $display("[TB] FAIL reset_dat got=%h exp=0", busIf.DAT_O); end
    checks++;
    if (msip !== 1'b0) begin errors++; $display("[TB] FAIL reset_msip got=%0b exp=0", msip); end
    checks++;
    if (mtime !== 64'h0) begin errors++; $display("[TB] FAIL reset_mtime got=%h exp=0", mtime); end
    checks++;
    if (mtimecmp !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("[TB] FAIL reset_mtimecmp got=%h exp=ffffffffffffffff", mtimecmp);
    end
    rst = 1'b0;
    ackHigh = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (busIf.ACK_O !== 1'b0) ackHigh++;
    end
    checks++;
    if (ackHigh != 0) begin errors++; $display("[TB] FAIL idle_ack got=%0d high cycles exp=0", ackHigh); end
    busAccess(3'b010, 1'b0, 32'h0, ack, dat, mt);
    checks++;
    if (ack !== 1'b1 || dat !== 32'd2) begin
      errors++; $display("[TB] FAIL mtime_lo_after_25 got ack=%0b dat=%h exp ack=1 dat=2", ack, dat);
    end
    busAccess(3'b011, 1'b0, 32'h0, ack, dat, mt);
    checks++;
    if (dat !== 32'h0) begin errors++; $display("[TB] FAIL mtime_hi_after_25 got=%h exp=0", dat); end
    busAccess(3'b100, 1'b0, 32'h0, ack, dat, mt);
    checks++;
    if (dat !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL mtimecmp_lo_reset got=%h exp=ffffffff", dat); end
    busAccess(3'b101, 1'b0, 32'h0, ack, dat, mt);
    checks++;
    if (dat !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL mtimecmp_hi_reset got=%h exp=ffffffff", dat); end
    checks++;
    if (msip !== 1'b0) begin errors++; $display("[TB] FAIL msip_idle got=%0b exp=0", msip); end
  endtask

  // CYC/STB held across a write then a read: ACK_O must pulse 1-0-1.
  task automatic test_back_to_back();
    busIf.ADR_I = 3'b000;
    busIf.DAT_I = 32'hA5A5_1235;
    busIf.WE_I  = 1'b1;
    busIf.CYC_I = 1'b1;
    busIf.STB_I = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busIf.ACK_O !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ack1 got=%0b exp=1", busIf.ACK_O); end
    busIf.WE_I = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busIf.ACK_O !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ack0 got=%0b exp=0", busIf.ACK_O); end
    @(posedge clk);
    #1;
    checks++;
    if (busIf.ACK_O !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ack2 got=%0b exp=1", busIf.ACK_O); end
    checks++;
    if (busIf.DAT_O !== 32'hA5A5_1235) begin
      errors++; $display("[TB] FAIL b2b_read got=%h exp=a5a51235", busIf.DAT_O);
    end
    checks++;
    if (msip !== 1'b1) begin errors++; $display("[TB] FAIL b2b_msip got=%0b exp=1", msip); end
    busIf.CYC_I = 1'b0;
    busIf.STB_I = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busIf.ACK_O !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drop got=%0b exp=0", busIf.ACK_O); end
  endtask

  task automatic test_mtime_write();
    logic        ack;
    logic [31:0] dat;
    logic [63:0] mt;
    logic [31:0] d;
    d = $urandom & 32'h7FFF_FFFF;
    busAccess(3'b010, 1'b1, d, ack, dat, mt);
    checks++;
    if (mt !== {32'h0, d}) begin errors++; $display("[TB] FAIL mtime_lo_write got=%h exp=%h", mt, {32'h0, d}); end
    busAccess(3'b010, 1'b0, 32'h0, ack, dat, mt);
    checks++;
    if (dat !== d && dat !== d + 32'd1) begin
      errors++; $display("[TB] FAIL mtime_lo_readback got=%h exp=%h or %h", dat, d, d + 32'd1);
    end
  endtask

  task automatic test_mtime_carry();
    logic        ack;
    logic [31:0] dat;
    logic [63:0] mt;
    logic [63:0] prev;
    int          waited;
    bit          seen;
    // Align to a tick so both half writes land well before the next one.
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      prev = mtime;
      @(posedge clk);
      #1;
      if (mtime != prev) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("[TB] FAIL tick_sync got=no tick exp=tick within 20 cycles"); end
    busAccess(3'b010, 1'b1, 32'hFFFF_FFFF, ack, dat, mt);
    busAccess(3'b011, 1'b1, 32'h0, ack, dat, mt);
    checks++;
    if (mtime !== 64'h0000_0000_FFFF_FFFF) begin
      errors++; $display("[TB] FAIL carry_pre got=%h exp=00000000ffffffff", mtime);
    end
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < 15) begin
      prev = mtime;
      @(posedge clk);
      #1;
      waited++;
      if (mtime != prev) seen = 1'b1;
    end
    checks++;
    if (!seen || mtime !== 64'h0000_0001_0000_0000) begin
      errors++; $display("[TB] FAIL carry_tick got=%h exp=0000000100000000", mtime);
    end
  endtask

  task automatic test_mtimecmp();
    logic        ack;
    logic [31:0] dat;
    logic [63:0] mt;
    logic [31:0] dLo;
    logic [31:0] dHi;
    dLo = $urandom;
    dHi = $urandom;
    busAccess(3'b100, 1'b1, dLo, ack, dat, mt);
    busAccess(3'b101, 1'b1, dHi, ack, dat, mt);
    busAccess(3'b100, 1'b0, 32'h0, ack, dat, mt);
    checks++;
    if (dat !== dLo) begin errors++; $display("[TB] FAIL mtimecmp_lo got=%h exp=%h", dat, dLo); end
    busAccess(3'b101, 1'b0, 32'h0, ack, dat, mt);
    checks++;
    if (dat !== dHi) begin errors++; $display("[TB] FAIL mtimecmp_hi got=%h exp=%h", dat, dHi); end
    checks++;
    if (mtimecmp !== {dHi, dLo}) begin
      errors++; $display("[TB] FAIL mtimecmp_out got=%h exp=%h", mtimecmp, {dHi, dLo});
    end
    checks++;
    if (mtime[63:32] !== 32'h1) begin errors++; $display("[TB] FAIL mtime_untouched got=%h exp=1", mtime[63:32]); end
  endtask

  task automatic test_reset_mid();
    logic        ack;
    logic [31:0] dat;
    logic [63:0] mt;
    busIf.ADR_I = 3'b000;
    busIf.DAT_I = 32'hFFFF_FFFF;
    busIf.WE_I  = 1'b1;
    busIf.CYC_I = 1'b1;
    busIf.STB_I = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busIf.ACK_O !== 1'b1 || msip !== 1'b1) begin
      errors++; $display("[TB] FAIL mid_write got ack=%0b msip=%0b exp 1 1", busIf.ACK_O, msip);
    end
    rst = 1'b1;
    busIf.CYC_I = 1'b0;
    busIf.STB_I = 1'b0;
    busIf.WE_I  = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busIf.ACK_O !== 1'b0 || msip !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_reset got ack=%0b msip=%0b exp 0 0", busIf.ACK_O, msip);
    end
    checks++;
    if (mtimecmp !== 64'hFFFF_FFFF_FFFF_FFFF || mtime !== 64'h0) begin
      errors++; $display("[TB] FAIL mid_reset_timers got mtime=%h cmp=%h", mtime, mtimecmp);
    end
    rst = 1'b0;
    busAccess(3'b000, 1'b1, 32'h0000_0005, ack, dat, mt);
    busAccess(3'b110, 1'b1, 32'hDEAD_BEEF, ack, dat, mt);
    checks++;
    if (ack !== 1'b1) begin errors++; $display("[TB] FAIL unmapped_write_ack got=%0b exp=1", ack); end
    busAccess(3'b001, 1'b0, 32'h0, ack, dat, mt);
    checks++;
    if (dat !== 32'h5) begin errors++; $display("[TB] FAIL msip_alias_read got=%h exp=5", dat); end
    busAccess(3'b110, 1'b0, 32'h0, ack, dat, mt);
    checks++;
    if (ack !== 1'b1 || dat !== 32'h0) begin
      errors++; $display("[TB] FAIL unmapped_read got ack=%0b dat=%h exp ack=1 dat=0", ack, dat);
    end
  endtask

  initial begin
    busIf.ADR_I = 3'b000;
    busIf.DAT_I = 32'h0;
    busIf.WE_I  = 1'b0;
    busIf.CYC_I = 1'b0;
    busIf.STB_I = 1'b0;
    $display("[TB] starting csr_mem tests");
    test_reset();
    test_back_to_back();
    test_mtime_write();
    test_mtime_carry();
    test_mtimecmp();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
